round_robin_arbiter: RTL and testbench

//  Shares one WIDTH-bit datapath (e.g. the memory/ALU operand bus) among 2**SELECT_WIDTH requesters.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/round_robin_arbiter.sv | 110 +++++++++++
 tb/tb_round_robin_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int ONEHOT_MAX   = 64;
  localparam int ONEHOT_IDX_W = 6;

  function automatic logic [ONEHOT_MAX-1:0] onehot_of(input logic [ONEHOT_IDX_W-1:0] idx);
    logic [ONEHOT_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority search: first requester after last_owner, wrapping, last_owner checked last.
module rr_priority_picker #(
  parameter int SELECT_WIDTH = 2
) (
  input  logic [2**SELECT_WIDTH-1:0] req,
  input  logic [SELECT_WIDTH-1:0]    last_owner,
  output logic                       found,
  output logic [SELECT_WIDTH-1:0]    pick_index
);

  localparam int N = 2**SELECT_WIDTH;

  logic [SELECT_WIDTH-1:0] cand;

  // Offset N truncates to 0, so last_owner itself is the final candidate.
  always_comb begin
    found      = 1'b0;
    pick_index = last_owner;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_owner + SELECT_WIDTH'(k);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick_index = cand;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit datapath.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ARB_IDLE | no owner, bus_valid low, waiting for any request
//   ARB_BUSY | one owner granted until it releases, drops req or times out
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SELECT_WIDTH = 2,
  parameter int MAX_HOLD     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2**SELECT_WIDTH-1:0]  req,
  input  logic [2**SELECT_WIDTH-1:0]  release_in,
  input  logic [WIDTH-1:0]            data_in [2**SELECT_WIDTH],
  output logic [2**SELECT_WIDTH-1:0]  grant,
  output logic [SELECT_WIDTH-1:0]     index,
  output logic                        bus_valid,
  output logic [WIDTH-1:0]            data_out,
  output logic                        timeout
);

  localparam int N = 2**SELECT_WIDTH;

  arb_state_t              state_q, state_d;
  logic [N-1:0]            grant_d;
  logic [SELECT_WIDTH-1:0] index_d, last_q, last_d, pick_index;
  logic                    bus_valid_d, timeout_d, found, take, new_grant, hold_expired;

  rr_priority_picker #(.SELECT_WIDTH(SELECT_WIDTH)) u_picker (
    .req        (req),
    .last_owner (last_q),
    .found      (found),
    .pick_index (pick_index)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_cnt;

  // Down-counter loaded on each new grant; reaching zero marks the last allowed cycle.
  always_ff @(posedge clk) begin
    if (reset)                                      hold_cnt <= '0;
    else if (new_grant)                             hold_cnt <= HOLD_W'(MAX_HOLD - 1);
    else if (state_q == ARB_BUSY && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
  end

  assign hold_expired = (state_q == ARB_BUSY) && (hold_cnt == '0);
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    index_d     = index;
    last_d      = last_q;
    bus_valid_d = bus_valid;
    timeout_d   = 1'b0;
    take        = 1'b0;
    new_grant   = 1'b0;
    unique case (state_q)
      ARB_IDLE: take = found;
      ARB_BUSY: begin
        if (!req[index] || release_in[index] || hold_expired) begin
          timeout_d = hold_expired && req[index] && !release_in[index];
          take      = found;
          if (!found) begin
            state_d     = ARB_IDLE;
            grant_d     = '0;
            bus_valid_d = 1'b0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (take) begin
      state_d     = ARB_BUSY;
      grant_d     = N'(onehot_of(ONEHOT_IDX_W'(pick_index)));
      index_d     = pick_index;
      last_d      = pick_index;
      bus_valid_d = 1'b1;
      new_grant   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      grant     <= '0;
      index     <= '0;
      last_q    <= SELECT_WIDTH'(N - 1);
      bus_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      index     <= index_d;
      last_q    <= last_d;
      bus_valid <= bus_valid_d;
      timeout   <= timeout_d;
    end
  end

  assign data_out = bus_valid ? data_in[index] : '0;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-free rotation model.
module tb_round_robin_arbiter;

  localparam int WIDTH    = 16;
  localparam int SEL_W    = 2;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     release_in = '0;
  logic [WIDTH-1:0] data_in [N];
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] index;
  logic             bus_valid;
  logic [WIDTH-1:0] data_out;
  logic             timeout;

  int n_checks = 0;
  int n_errors = 0;

  // reference state: plain integers
  bit m_busy;
  int m_index, m_last, m_hold;
  bit m_tmo;

  round_robin_arbiter #(.WIDTH(WIDTH), .SELECT_WIDTH(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .release_in(release_in), .data_in(data_in),
    .grant(grant), .index(index), .bus_valid(bus_valid), .data_out(data_out), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    int  pick;
    bit  forced;
    if (reset) begin
      m_busy = 0; m_index = 0; m_last = N - 1; m_hold = 0; m_tmo = 0;
      return;
    end
    m_tmo  = 0;
    forced = m_busy && req[m_index] && !release_in[m_index] && TMO_EN && (m_hold >= MAX_HOLD);
    if (!m_busy || !req[m_index] || release_in[m_index] || forced) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
      m_tmo = forced;
      if (pick >= 0) begin
        m_busy = 1; m_index = pick; m_last = pick; m_hold = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_hold++;
    end
  endfunction

  task automatic check_all();
    logic [N-1:0]     exp_grant;
    logic [WIDTH-1:0] exp_data;
    exp_grant = '0;
    exp_data  = '0;
    if (m_busy) begin
      exp_grant[m_index] = 1'b1;
      exp_data = data_in[m_index];
    end
    check_val("grant", 32'(grant), 32'(exp_grant));
    check_val("index", 32'(index), 32'(m_index));
    check_val("bus_valid", 32'(bus_valid), 32'(m_busy));
    check_val("data_out", 32'(data_out), 32'(exp_data));
    check_val("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] rel, input logic rst);
    @(negedge clk);
    req = r; release_in = rel; reset = rst;
    for (int i = 0; i < N; i++) data_in[i] = WIDTH'($urandom);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r, rel, oh;
    logic rst;
    for (int i = 0; i < N; i++) data_in[i] = '0;

    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b1);
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_valid", 32'(bus_valid), 32'h0);
    check_val("rst_index", 32'(index), 32'h0);

    // first grant goes to requester 0
    cycle(4'b0101, '0, 1'b0);
    check_val("t1_grant", 32'(grant), 32'h1);
    check_val("t1_data", 32'(data_out), 32'(data_in[0]));

    // release with another request pending: direct handoff
    cycle(4'b0101, 4'b0001, 1'b0);
    check_val("t2_grant", 32'(grant), 32'h4);
    check_val("t2_index", 32'(index), 32'h2);

    cycle('0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      oh = '0;
      if (i > 0) oh[index] = 1'b1;
      cycle(4'b1111, oh, 1'b0);
      check_val("t3_rotation", 32'(index), 32'(seq[i]));
    end

    cycle(4'b0100, 4'b0001, 1'b0);
    check_val("t4_owner2", 32'(index), 32'h2);
    cycle('0, '0, 1'b0);
    check_val("t4_valid", 32'(bus_valid), 32'h0);
    check_val("t4_grant", 32'(grant), 32'h0);
    check_val("t4_data", 32'(data_out), 32'h0);
    check_val("t4_index", 32'(index), 32'h2);

    cycle(4'b1000, '0, 1'b0);
    check_val("t5_owner3", 32'(index), 32'h3);
    cycle(4'b1000, '0, 1'b1);
    check_val("t5_rst_grant", 32'(grant), 32'h0);
    check_val("t5_rst_valid", 32'(bus_valid), 32'h0);
    cycle(4'b1001, '0, 1'b0);
    check_val("t5_regrant", 32'(index), 32'h0);

    cycle('0, '0, 1'b1);
    cycle(4'b0011, '0, 1'b0);
    cycle(4'b0011, 4'b0001, 1'b0);
    check_val("t6_owner1", 32'(index), 32'h1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      cycle(4'b0011, '0, 1'b0);
      check_val("t6_hold", 32'(index), 32'h1);
    end
    cycle(4'b0011, '0, 1'b0);
    check_val("t6_forced_index", 32'(index), 32'h0);
    check_val("t6_timeout", 32'(timeout), 32'h1);
    cycle(4'b0011, '0, 1'b0);
    check_val("t6_timeout_pulse", 32'(timeout), 32'h0);
`else
    for (int i = 0; i < 100; i++) cycle(4'b0011, '0, 1'b0);
    check_val("t6_still_owner1", 32'(index), 32'h1);
    check_val("t6_still_valid", 32'(bus_valid), 32'h1);
    check_val("t6_no_timeout", 32'(timeout), 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      r   = N'($urandom);
      if (m_busy && $urandom_range(0, 3) != 0) r[m_index] = 1'b1;
      rel = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      rst = ($urandom_range(0, 99) == 0);
      cycle(r, rel, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
